// File: rtl/led_matrix_scanner.sv
// Row-scan driver for an LED dot matrix: one-hot row drive with blanking gap,
// double-buffered frame store, and a tear-free bank swap at the frame wrap.
module led_matrix_scanner #(
   parameter int ROW            = 8,
   parameter int COL            = 8,
   parameter int ROW_W          = 3,
   parameter int DWELL          = 1000,
   parameter int BLANK          = 4,
   parameter bit COL_ACTIVE_LOW = 1'b1,
   parameter bit ROW_ACTIVE_LOW = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             wr_en,
   input  logic [ROW_W-1:0] wr_row,
   input  logic [COL-1:0]   wr_data,
   input  logic             swap_req,
   output logic [ROW-1:0]   row_sel,
   output logic [COL-1:0]   col_out,
   output logic [ROW_W-1:0] cur_row,
   output logic             frame_start,
   output logic             swap_pending,
   output logic             swap_done
);

   localparam int MAX_CNT = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int TW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
   localparam logic [TW-1:0]    DWELL_LAST = TW'(DWELL - 1);
   localparam logic [TW-1:0]    BLANK_LAST = TW'((BLANK > 0) ? BLANK - 1 : 0);
   localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROW - 1);
   localparam logic [ROW-1:0]   ROW_OFF    = {ROW{ROW_ACTIVE_LOW}};
   localparam logic [COL-1:0]   COL_OFF    = {COL{COL_ACTIVE_LOW}};

   typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

   state_t           state, state_next;
   logic [TW-1:0]    timer, timer_next;
   logic [ROW_W-1:0] row_next;
   logic             front, front_next;
   logic             pending_next, frame_start_next, swap_done_next;
   logic [ROW-1:0]   row_onehot, row_sel_next;
   logic [COL-1:0]   show_data, col_next;
   logic             wr_ok;
   logic [COL-1:0]   mem [2][ROW];

   // A full power-of-two row space makes every address legal.
   generate
      if (ROW == (1 << ROW_W)) begin : g_full_rows
         assign wr_ok = wr_en;
      end else begin : g_partial_rows
         assign wr_ok = wr_en && ({1'b0, wr_row} < (ROW_W+1)'(ROW));
      end
   endgenerate

   // Writes land in the bank that is "back" before this edge, even on a swap edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < ROW; r++) begin
               mem[b][r] <= '0;
            end
         end
      end else if (wr_ok) begin
         mem[!front][wr_row] <= wr_data;
      end
   end

   always_comb begin
      state_next       = state;
      row_next         = cur_row;
      timer_next       = timer + 1'b1;
      front_next       = front;
      pending_next     = swap_pending | swap_req;
      frame_start_next = 1'b0;
      swap_done_next   = 1'b0;
      if (!enable) begin
         state_next = S_IDLE;
         row_next   = '0;
         timer_next = '0;
      end else begin
         case (state)
            S_IDLE: begin
               state_next       = (BLANK > 0) ? S_BLANK : S_SHOW;
               row_next         = '0;
               timer_next       = '0;
               frame_start_next = 1'b1;
            end
            S_BLANK: begin
               if (timer == BLANK_LAST) begin
                  state_next = S_SHOW;
                  timer_next = '0;
               end
            end
            S_SHOW: begin
               if (timer == DWELL_LAST) begin
                  state_next = (BLANK > 0) ? S_BLANK : S_SHOW;
                  timer_next = '0;
                  if (cur_row == ROW_LAST) begin
                     row_next         = '0;
                     frame_start_next = 1'b1;
                     if (swap_pending || swap_req) begin
                        front_next     = !front;
                        swap_done_next = 1'b1;
                        pending_next   = 1'b0;
                     end
                  end else begin
                     row_next = cur_row + 1'b1;
                  end
               end
            end
            default: begin
               state_next = S_IDLE;
               row_next   = '0;
               timer_next = '0;
            end
         endcase
      end
   end

   // Outputs are precomputed from the next state so they change on the same edge;
   // a same-edge write into the bank about to become front is forwarded.
   always_comb begin
      row_onehot           = '0;
      row_onehot[row_next] = 1'b1;
      show_data            = mem[front_next][row_next];
      if (wr_ok && (front_next != front) && (wr_row == row_next)) begin
         show_data = wr_data;
      end
      row_sel_next = ROW_OFF;
      col_next     = COL_OFF;
      if (state_next == S_SHOW) begin
         row_sel_next = row_onehot ^ ROW_OFF;
         col_next     = show_data ^ COL_OFF;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         timer        <= '0;
         cur_row      <= '0;
         front        <= 1'b0;
         swap_pending <= 1'b0;
         frame_start  <= 1'b0;
         swap_done    <= 1'b0;
         row_sel      <= ROW_OFF;
         col_out      <= COL_OFF;
      end else begin
         state        <= state_next;
         timer        <= timer_next;
         cur_row      <= row_next;
         front        <= front_next;
         swap_pending <= pending_next;
         frame_start  <= frame_start_next;
         swap_done    <= swap_done_next;
         row_sel      <= row_sel_next;
         col_out      <= col_next;
      end
   end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Scoreboard bench for led_matrix_scanner: two builds (BLANK=2 and BLANK=0)
// driven in lockstep and checked against a frame-position reference model.
module tb_led_matrix_scanner;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic       wr_en;
   logic [2:0] wr_row;
   logic [7:0] wr_data;
   logic       swap_req;

   logic [7:0] row_sel_a, col_out_a, row_sel_b, col_out_b;
   logic [2:0] cur_row_a, cur_row_b;
   logic       frame_start_a, swap_pending_a, swap_done_a;
   logic       frame_start_b, swap_pending_b, swap_done_b;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0] row_sel;
      logic [7:0] col;
      logic [2:0] cur_row;
      logic       fs;
      logic       pend;
      logic       sd;
   } exp_t;

   exp_t sb[$];

   bit         m_on[2], m_front[2], m_pend[2], m_fs[2], m_sd[2];
   int         m_pos[2];
   logic [7:0] m_mem[2][2][8];

   led_matrix_scanner #(.ROW(8), .COL(8), .ROW_W(3), .DWELL(4), .BLANK(2),
                        .COL_ACTIVE_LOW(1'b1), .ROW_ACTIVE_LOW(1'b0)) dut_a (
      .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en), .wr_row(wr_row),
      .wr_data(wr_data), .swap_req(swap_req), .row_sel(row_sel_a), .col_out(col_out_a),
      .cur_row(cur_row_a), .frame_start(frame_start_a), .swap_pending(swap_pending_a),
      .swap_done(swap_done_a));

   led_matrix_scanner #(.ROW(8), .COL(8), .ROW_W(3), .DWELL(4), .BLANK(0),
                        .COL_ACTIVE_LOW(1'b1), .ROW_ACTIVE_LOW(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en), .wr_row(wr_row),
      .wr_data(wr_data), .swap_req(swap_req), .row_sel(row_sel_b), .col_out(col_out_b),
      .cur_row(cur_row_b), .frame_start(frame_start_b), .swap_pending(swap_pending_b),
      .swap_done(swap_done_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic resetModel();
      for (int k = 0; k < 2; k++) begin
         m_on[k] = 0; m_front[k] = 0; m_pend[k] = 0; m_fs[k] = 0; m_sd[k] = 0; m_pos[k] = 0;
         for (int b = 0; b < 2; b++)
            for (int r = 0; r < 8; r++) m_mem[k][b][r] = 8'h00;
      end
   endtask

   // Model tracks position inside the frame; row and blank/show phase derive from it.
   task automatic modelStep(input int k, input logic en, input logic we, input logic [2:0] wrow,
                            input logic [7:0] wdata, input logic sreq);
      int per;
      bit old_front;
      per = 8 * (((k == 0) ? 2 : 0) + 4);
      old_front = m_front[k];
      m_fs[k] = 0;
      m_sd[k] = 0;
      if (!en) begin
         m_on[k] = 0; m_pos[k] = 0; m_pend[k] = m_pend[k] | sreq;
      end else if (!m_on[k]) begin
         m_on[k] = 1; m_pos[k] = 0; m_fs[k] = 1; m_pend[k] = m_pend[k] | sreq;
      end else if (m_pos[k] == per - 1) begin
         m_pos[k] = 0; m_fs[k] = 1;
         if (m_pend[k] | sreq) begin
            m_front[k] = !m_front[k]; m_sd[k] = 1; m_pend[k] = 0;
         end
      end else begin
         m_pos[k]++; m_pend[k] = m_pend[k] | sreq;
      end
      if (we) m_mem[k][!old_front][wrow] = wdata;
   endtask

   function automatic exp_t modelOut(input int k);
      exp_t e;
      int b;
      int per;
      int row;
      int ph;
      b   = (k == 0) ? 2 : 0;
      per = b + 4;
      row = m_pos[k] / per;
      ph  = m_pos[k] % per;
      e.row_sel = 8'h00; e.col = 8'hFF; e.cur_row = 3'd0;
      e.fs = m_fs[k]; e.pend = m_pend[k]; e.sd = m_sd[k];
      if (m_on[k]) begin
         e.cur_row = row[2:0];
         if (ph >= b) begin
            e.row_sel = 8'h01 << row;
            e.col     = ~m_mem[k][m_front[k]][row];
         end
      end
      return e;
   endfunction

   task automatic compareInst(input int k, input exp_t e);
      string p;
      p = (k == 0) ? "a_" : "b_";
      if (k == 0) begin
         checkOutput({p, "row_sel"}, row_sel_a, e.row_sel);
         checkOutput({p, "col_out"}, col_out_a, e.col);
         checkOutput({p, "cur_row"}, cur_row_a, e.cur_row);
         checkOutput({p, "frame_start"}, frame_start_a, e.fs);
         checkOutput({p, "swap_pending"}, swap_pending_a, e.pend);
         checkOutput({p, "swap_done"}, swap_done_a, e.sd);
      end else begin
         checkOutput({p, "row_sel"}, row_sel_b, e.row_sel);
         checkOutput({p, "col_out"}, col_out_b, e.col);
         checkOutput({p, "cur_row"}, cur_row_b, e.cur_row);
         checkOutput({p, "frame_start"}, frame_start_b, e.fs);
         checkOutput({p, "swap_pending"}, swap_pending_b, e.pend);
         checkOutput({p, "swap_done"}, swap_done_b, e.sd);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic we, input logic [2:0] wrow,
                                input logic [7:0] wdata, input logic sreq);
      exp_t e;
      enable = en; wr_en = we; wr_row = wrow; wr_data = wdata; swap_req = sreq;
      for (int k = 0; k < 2; k++) begin
         modelStep(k, en, we, wrow, wdata, sreq);
         sb.push_back(modelOut(k));
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         e = sb.pop_front();
         compareInst(k, e);
      end
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
   endtask

   // Runs until the BLANK=2 build reaches the given frame position, bounded.
   task automatic runUntil(input int pos, input int limit);
      int n;
      n = 0;
      while (!(m_on[0] && m_pos[0] == pos) && n < limit) begin
         applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
         n++;
      end
      if (!(m_on[0] && m_pos[0] == pos)) checkOutput("wait_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; wr_en = 1'b0; wr_row = 3'd0; wr_data = 8'h00; swap_req = 1'b0;
      resetModel();
      @(posedge clk);
      #1;
      checkOutput("rst_row_sel", row_sel_a, 8'h00);
      checkOutput("rst_col_out", col_out_a, 8'hFF);
      checkOutput("rst_cur_row", cur_row_a, 3'd0);
      checkOutput("rst_pending", swap_pending_a, 1'b0);
      checkOutput("rst_row_sel_b", row_sel_b, 8'h00);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      $display("[TB] empty buffer scan");
      applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
      applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
      idleCycles(54);

      $display("[TB] fill back buffer with 81 and swap");
      for (int r = 0; r < 8; r++) applyStimulus(1'b1, 1'b1, 3'(r), 8'h81, 1'b0);
      applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 1'b1);
      runUntil(47, 100);
      applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
      runUntil(2, 20);
      checkOutput("row0_after_swap", col_out_a, 8'h7E);
      checkOutput("pend_cleared", swap_pending_a, 1'b0);

      $display("[TB] hidden writes and merged swap requests");
      for (int r = 0; r < 8; r++) applyStimulus(1'b1, 1'b1, 3'(r), 8'h01 << r, 1'b0);
      idleCycles(5);
      applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 1'b1);
      idleCycles(3);
      applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 1'b1);
      applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 1'b1);
      idleCycles(70);

      $display("[TB] write plus swap on wrap edge");
      runUntil(47, 100);
      applyStimulus(1'b1, 1'b1, 3'd0, 8'h3C, 1'b1);
      runUntil(2, 20);
      checkOutput("wrap_write_row0", col_out_a, 8'hC3);
      idleCycles(10);

      $display("[TB] disable mid row 5");
      runUntil(33, 60);
      applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
      checkOutput("dis_row_sel", row_sel_a, 8'h00);
      checkOutput("dis_cur_row", cur_row_a, 3'd0);
      checkOutput("dis_pending", swap_pending_a, 1'b1);
      applyStimulus(1'b0, 1'b1, 3'd5, 8'hA5, 1'b0);
      applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
      checkOutput("reen_frame_start", frame_start_a, 1'b1);
      idleCycles(60);

      $display("[TB] async reset mid scan");
      runUntil(20, 60);
      rst_n = 1'b0;
      #2;
      checkOutput("arst_row_sel", row_sel_a, 8'h00);
      checkOutput("arst_col_out", col_out_a, 8'hFF);
      checkOutput("arst_cur_row", cur_row_a, 3'd0);
      checkOutput("arst_row_sel_b", row_sel_b, 8'h00);
      checkOutput("arst_col_out_b", col_out_b, 8'hFF);
      resetModel();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idleCycles(50);
      applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 1'b1);
      idleCycles(100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
